// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared types and sizing helpers for the FIFO drain unpacker.
package fifo_drain_pkg;

  localparam int WBUF_DEPTH = 2;

  // Pointer into the two-entry word buffer and its occupancy (0..2).
  typedef logic       wbuf_ptr_t;
  typedef logic [1:0] wbuf_occ_t;

  // Lane index width: clog2 of the lane count, never narrower than one bit.
  function automatic int lane_idx_w(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/drain_word_buf.sv
// rtl/drain_word_buf.sv - two-entry register FIFO for drained words, head visible with no read latency.
module drain_word_buf
  import fifo_drain_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output wbuf_occ_t    occ
);

  logic [W-1:0] mem_q [WBUF_DEPTH];
  logic [W-1:0] mem_d [WBUF_DEPTH];
  wbuf_ptr_t    wr_ptr_q, wr_ptr_d;
  wbuf_ptr_t    rd_ptr_q, rd_ptr_d;
  wbuf_occ_t    occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_drain_unpacker.sv
// rtl/fifo_drain_unpacker.sv - drains wide sync-FIFO words and emits them as narrow lanes on a valid/ready stream.
// Define FIFO_DRAIN_MSB_FIRST_EN to emit the most significant lane of each word first.
module fifo_drain_unpacker
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDE = 64,
  parameter int OUT_WIDE  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DATA_WIDE-1:0] fifo_dout,
  input  logic                 flush,
  output logic [OUT_WIDE-1:0]  out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int RATIO = DATA_WIDE / OUT_WIDE;
  localparam int LW    = lane_idx_w(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  if (RATIO < 2 || (DATA_WIDE % OUT_WIDE) != 0) begin : g_bad_cfg
    $error("fifo_drain_unpacker: DATA_WIDE must be a multiple of OUT_WIDE with at least two lanes");
  end

  logic          run_q, run_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic [LW-1:0] lane_idx_q, lane_idx_d;
  logic [LW-1:0] lane_sel;

  wbuf_occ_t           occ;
  logic [DATA_WIDE-1:0] head_data;
  logic                buf_push, buf_pop;
  logic                lane_valid, xfer;
  logic [OUT_WIDE-1:0] lanes [RATIO];

  drain_word_buf #(.W(DATA_WIDE)) u_word_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (buf_push),
    .push_data (fifo_dout),
    .pop       (buf_pop),
    .head_data (head_data),
    .occ       (occ)
  );

  // Read issue looks only at registered state so out_ready never reaches fifo_rd_en.
  always_comb begin
    fifo_rd_en = run_q && !fifo_empty && !flush &&
                 ((occ + {1'b0, inflight_q}) < 2'd2);
  end

  always_comb begin
    lane_valid = (occ != '0);
    xfer       = lane_valid && out_ready;
    buf_push   = inflight_q && !drop_q && !flush;
    buf_pop    = xfer && (lane_idx_q == LAST_LANE) && !flush;
    run_d      = 1'b1;
    inflight_d = fifo_rd_en;
    drop_d     = flush && inflight_q;
    lane_idx_d = lane_idx_q;
    if (flush) begin
      lane_idx_d = '0;
    end else if (xfer) begin
      lane_idx_d = (lane_idx_q == LAST_LANE) ? '0 : lane_idx_q + LW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < RATIO; i++) begin
      lanes[i] = head_data[i*OUT_WIDE +: OUT_WIDE];
    end
`ifdef FIFO_DRAIN_MSB_FIRST_EN
    lane_sel = LAST_LANE - lane_idx_q;
`else
    lane_sel = lane_idx_q;
`endif
    out_valid = lane_valid;
    out_data  = lane_valid ? lanes[lane_sel] : '0;
    out_last  = lane_valid && (lane_idx_q == LAST_LANE);
    busy      = lane_valid || inflight_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      lane_idx_q <= '0;
    end else begin
      run_q      <= run_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      lane_idx_q <= lane_idx_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_unpacker.sv
// tb/tb_fifo_drain_unpacker.sv - scoreboard bench for fifo_drain_unpacker with a 1-clk-latency FIFO model.
module tb_fifo_drain_unpacker;

  localparam int DW = 64;
  localparam int OW = 16;
  localparam int R  = DW / OW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          flush;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  fifo_drain_unpacker #(.DATA_WIDE(DW), .OUT_WIDE(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  logic [DW-1:0] fifo_q [$];
  logic [OW:0]   exp_q  [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            xfer_cnt = 0;
  int            rd_cnt   = 0;

  logic          s_rd, s_valid, s_last, s_busy;
  logic [OW-1:0] s_data;

  function automatic logic [OW-1:0] lane_of(input logic [DW-1:0] w, input int k);
    logic [DW-1:0] t;
    int pos;
`ifdef FIFO_DRAIN_MSB_FIRST_EN
    pos = R - 1 - k;
`else
    pos = k;
`endif
    t = w >> (pos * OW);
    return t[OW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // One clock: sample just after the inputs settle, then model the FIFO's registered dout.
  task automatic cycle();
    logic          rd;
    logic          fl;
    logic [DW-1:0] w;
    #1;
    rd      = fifo_rd_en;
    fl      = flush;
    s_rd    = fifo_rd_en;
    s_valid = out_valid;
    s_data  = out_data;
    s_last  = out_last;
    s_busy  = busy;
    if (rd) begin
      rd_cnt++;
      check("rd_when_empty", fifo_empty, 1'b0);
    end
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) begin
      w         = fifo_q.pop_front();
      fifo_dout = w;
      for (int k = 0; k < R; k++) exp_q.push_back({(k == R - 1), lane_of(w, k)});
    end else begin
      fifo_dout = rand_word();
    end
    fifo_empty = (fifo_q.size() == 0);
    if (fl) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 300) begin
      cycle();
      n++;
    end
    check({name, "_drained"}, (n < 300), 1'b1);
    cycle();
    check({name, "_idle_busy"}, s_busy, 1'b0);
  endtask

  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic          prev_last;
  logic [OW:0]   mon_e;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (!out_valid) check("idle_outputs", {out_last, out_data}, '0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_lane: got %0h with no lane expected", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("lane", {out_last, out_data}, mon_e);
        end
        xfer_cnt++;
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w0, w1, w2;
    logic [DW-1:0] w3 [3];
    int n, nv, nl, x0;

    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    @(negedge clk);

    // Reset held with a non-empty FIFO, then a single known word.
    w0 = 64'h4444_3333_2222_1111;
    push_word(w0);
    repeat (2) cycle();
    check("rst_rd_en", s_rd, 1'b0);
    check("rst_valid", s_valid, 1'b0);
    check("rst_data", s_data, '0);
    check("rst_last", s_last, 1'b0);
    check("rst_busy", s_busy, 1'b0);
    rst_n = 1'b1;
    cycle();
    cycle();
    check("rd_after_reset", s_rd, 1'b1);
    cycle();
    check("rd_single", s_rd, 1'b0);
    check("lat_valid_n1", s_valid, 1'b0);
    check("lat_busy_inflight", s_busy, 1'b1);
    cycle();
    check("lat_valid_n2", s_valid, 1'b1);
    check("w0_lane0", s_data, lane_of(w0, 0));
    check("w0_lane0_last", s_last, 1'b0);
    repeat (3) cycle();
    check("w0_lane3", s_data, lane_of(w0, 3));
    check("w0_lane3_last", s_last, 1'b1);
    cycle();
    check("w0_done_valid", s_valid, 1'b0);
    check("w0_done_busy", s_busy, 1'b0);

    // Backpressure: only two words may be taken.
    out_ready = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      w3[i] = rand_word();
      push_word(w3[i]);
    end
    repeat (10) cycle();
    check("bp_rd_count", rd_cnt, 2);
    check("bp_fifo_left", fifo_q.size(), 1);
    check("bp_valid", s_valid, 1'b1);
    check("bp_data", s_data, lane_of(w3[0], 0));
    drain("bp");

    // Streaming throughput: 8 words, 32 lanes back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(rand_word());
    n = 0;
    cycle();
    while (!s_valid && n < 10) begin
      cycle();
      n++;
    end
    check("tp_start", s_valid, 1'b1);
    nv = 1;
    nl = int'(s_last);
    for (int i = 1; i < 32; i++) begin
      cycle();
      nv += int'(s_valid);
      nl += int'(s_valid && s_last);
    end
    check("tp_lanes", nv, 32);
    check("tp_lasts", nl, 8);
    cycle();
    check("tp_after", s_valid, 1'b0);
    drain("tp");

    // Alternating ready over 4 words.
    x0 = xfer_cnt;
    for (int i = 0; i < 4; i++) push_word(rand_word());
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 200) begin
      out_ready = (n % 2 == 0);
      cycle();
      n++;
    end
    check("alt_lanes", xfer_cnt - x0, 16);
    drain("alt");

    // Flush at lane 2 of a word with the next read in flight.
    out_ready = 1'b0;
    w0 = rand_word();
    push_word(w0);
    n = 0;
    cycle();
    while (!s_valid && n < 10) begin
      cycle();
      n++;
    end
    check("fl_start", s_valid, 1'b1);
    out_ready = 1'b1;
    repeat (2) cycle();
    out_ready = 1'b0;
    w1 = rand_word();
    push_word(w1);
    cycle();
    check("fl_rd_issue", s_rd, 1'b1);
    check("fl_lane2", s_data, lane_of(w0, 2));
    flush = 1'b1;
    cycle();
    check("fl_busy_inflight", s_busy, 1'b1);
    flush = 1'b0;
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      nv += int'(s_valid);
    end
    check("fl_no_valid", nv, 0);
    check("fl_idle_busy", s_busy, 1'b0);
    w2 = rand_word();
    push_word(w2);
    flush = 1'b1;
    cycle();
    check("fl_blocks_rd", s_rd, 1'b0);
    flush = 1'b0;
    cycle();
    check("fl_new_rd", s_rd, 1'b1);
    cycle();
    check("fl_new_lat", s_valid, 1'b0);
    cycle();
    check("fl_new_valid", s_valid, 1'b1);
    check("fl_new_lane0", s_data, lane_of(w2, 0));
    drain("fl");

    // Random traffic, backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 6) push_word(rand_word());
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0;
    drain("rnd");

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_drain_unpacker.md
Name: fifo_drain_unpacker

Overview:
Consumer for the read side of the team's sync FIFO (rd_en/empty with 1-clk registered dout). It drains wide FIFO words, buffers up to two of them, and serializes each into DATA_WIDE/OUT_WIDE narrow lanes on a valid/ready stream. It sits between a FIFO and a narrow downstream datapath, such as a PE operand port. It hides the FIFO read latency so a FIFO holding data and a ready sink give one lane per cycle.

Parameters:
DATA_WIDE, 64, FIFO word width; must be a multiple of OUT_WIDE
OUT_WIDE, 16, output lane width
RATIO, DATA_WIDE/OUT_WIDE (derived localparam), lanes per word; RATIO >= 2 is required (elaboration check)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read strobe
fifo_dout  in  DATA_WIDE  FIFO read data, valid the cycle after fifo_rd_en
flush  in  1  sync discard of all buffered/in-flight data
out_data  out  OUT_WIDE  current lane
out_valid  out  1  lane valid
out_ready  in  1  sink accepts lane
out_last  out  1  current lane is last of its word
busy  out  1  words buffered or a read in flight

Behaviour:
- Reset: clk, rst_n asynchronous active-low.
  - Outputs: fifo_rd_en=0, out_valid=0, out_data=0, out_last=0, busy=0.
  - Internal: occupancy=0, inflight=0, lane_idx=0, drop=0.
- Read issue:
  - fifo_rd_en = !fifo_empty && !flush && (occ + inflight) < 2, using registered occ/inflight.
  - No combinational path from out_ready to fifo_rd_en.
  - Never reads an empty FIFO.
- Capture:
  - inflight <= fifo_rd_en.
  - When inflight=1 and drop=0, fifo_dout is written into the 2-entry word buffer at the tail.
- Latency: rd_en in cycle N; data captured at the end of N+1; out_valid in N+2.
- Output:
  - out_valid = (occ != 0).
  - out_data = head word bits [lane_idx*OUT_WIDE +: OUT_WIDE], LSB lane first; 0 when !out_valid.
  - out_last = out_valid && lane_idx == RATIO-1.
- Handshake:
  - Transfer on out_valid && out_ready: lane_idx increments.
  - At RATIO-1, lane_idx wraps to 0 and the head word is popped.
  - out_data/out_last hold stable while out_valid && !out_ready.
- Simultaneous capture and pop in one cycle: occ unchanged, order preserved.
- Throughput: sustained 1 lane/cycle when the FIFO stays non-empty and out_ready stays high, for any RATIO >= 2.
- Flush (synchronous):
  - Next cycle: occ=0 and lane_idx=0; fifo_rd_en is forced 0 in the flush cycle.
  - If a read was in flight during the flush cycle, drop <= 1 and that returning word is discarded.
  - drop clears after one cycle.
- busy = (occ != 0) || inflight.
- Async reset mid-operation discards all state immediately. The FIFO's own read pointer is not this block's concern.

Optional Feature:
Macro FIFO_DRAIN_MSB_FIRST_EN.
- Defined: lanes are emitted MSB first; lane k = bits [(RATIO-1-k)*OUT_WIDE +: OUT_WIDE].
- Undefined: LSB-first order, as above.
- Handshake, out_last and timing are identical in both builds.

Decomposition:
- Package fifo_drain_pkg: lane-index width function (clog2 of RATIO, minimum 1) and a word-buffer pointer typedef.
- Sub-module drain_word_buf: 2-entry register FIFO with push/pop/occ, no read latency.
- fifo_drain_unpacker top: read-issue/inflight/drop logic and lane counter.

Test Plan (DATA_WIDE=64, OUT_WIDE=16; bench models the FIFO with 1-clk dout):
1. Hold rst_n=0 with the FIFO non-empty -> fifo_rd_en=0, out_valid=0, out_data=0, busy=0. Release -> fifo_rd_en rises the next cycle.
2. One word 0x4444_3333_2222_1111, out_ready=1 -> rd_en for one cycle; out_valid 2 cycles later.
   - Lanes 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles; out_last only on 0x4444; busy low afterwards.
   - With FIFO_DRAIN_MSB_FIRST_EN: order 0x4444..0x1111.
3. 3 words, out_ready=0 -> rd_en asserted exactly twice, then held low; FIFO keeps 1 word; out_data stable at lane 0 of word 0.
4. 8 words, out_ready=1 -> 32 lanes in 32 consecutive cycles with no bubble, 8 out_last pulses, data in order.
5. out_ready toggling 1,0,1,0 over 4 words -> all 16 lanes in order, none duplicated or skipped; out_data/out_valid stable during stalls.
6. flush at lane 2 of word 0 while a read is in flight -> dropped return never appears.
   - out_valid stays 0 until a new read completes; the next word starts at lane 0.
